// File: rtl/csc_pkg.sv
// Shared state encoding and sparse-format constants for the CSC weight encoder.
package csc_pkg;

  localparam int D_WIDTH_DEF      = 16;
  localparam int A_WIDTH_DEF      = 4;
  localparam int W_ADDR_WIDTH_DEF = 4;

  // All-ones code of a field: largest zero run, or the entry capacity of the v/z RAM.
  function automatic int unsigned max_code(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  localparam int unsigned ZMAX      = max_code(A_WIDTH_DEF);
  localparam int unsigned ENTRY_CAP = max_code(W_ADDR_WIDTH_DEF);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_P    = 3'd1,
    STREAM    = 3'd2,
    CLOSE_COL = 3'd3,
    DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/csc_encoder_if.sv
// Dense weight stream in, v/z and p RAM write ports out, plus status.
interface csc_encoder_if #(
  parameter int D_WIDTH      = csc_pkg::D_WIDTH_DEF,
  parameter int A_WIDTH      = csc_pkg::A_WIDTH_DEF,
  parameter int W_ADDR_WIDTH = csc_pkg::W_ADDR_WIDTH_DEF
);

  logic                    start;
  logic [A_WIDTH-1:0]      cfg_cols;
  logic                    in_valid;
  logic                    in_ready;
  logic [D_WIDTH-1:0]      in_data;
  logic                    in_last;
  logic                    vz_w_en;
  logic [W_ADDR_WIDTH-1:0] vz_w_addr;
  logic [D_WIDTH-1:0]      v_data;
  logic [A_WIDTH-1:0]      z_data;
  logic                    p_w_en;
  logic [A_WIDTH-1:0]      p_w_addr;
  logic [W_ADDR_WIDTH-1:0] p_data;
  logic                    busy;
  logic                    done;
  logic                    err_ovf;

  modport master (
    output start, cfg_cols, in_valid, in_data, in_last,
    input  in_ready, vz_w_en, vz_w_addr, v_data, z_data,
    input  p_w_en, p_w_addr, p_data, busy, done, err_ovf
  );

  modport slave (
    input  start, cfg_cols, in_valid, in_data, in_last,
    output in_ready, vz_w_en, vz_w_addr, v_data, z_data,
    output p_w_en, p_w_addr, p_data, busy, done, err_ovf
  );

endinterface

// File: rtl/csc_entry_gen.sv
// Zero-run tracking and registered v/z entry for one accepted beat per cycle.
// Build option CSC_ZPAD_EN: a zero beyond the longest run emits a (0, ZMAX) pad entry.
module csc_entry_gen
  import csc_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat,
  input  logic [D_WIDTH-1:0] data,
  input  logic               col_start,
  output logic               emit,
  output logic               fmt_err,
  output logic [D_WIDTH-1:0] v,
  output logic [A_WIDTH-1:0] z
);

  localparam logic [A_WIDTH-1:0] ZMAX_C = A_WIDTH'(max_code(A_WIDTH));
  localparam logic [A_WIDTH-1:0] ONE_A  = A_WIDTH'(1'b1);

  logic [A_WIDTH-1:0] run_q, run_d;
  logic [A_WIDTH-1:0] z_q, z_d;
  logic [D_WIDTH-1:0] v_q, v_d;
  logic               zero_s;

  assign zero_s = (data == '0);

  // Run update and entry selection for the current beat.
  always_comb begin
    run_d   = run_q;
    v_d     = v_q;
    z_d     = z_q;
    emit    = 1'b0;
    fmt_err = 1'b0;
    if (col_start) begin
      run_d = '0;
    end else if (beat) begin
      if (!zero_s) begin
        emit  = 1'b1;
        v_d   = data;
        z_d   = run_q;
        run_d = '0;
      end else if (run_q != ZMAX_C) begin
        run_d = run_q + ONE_A;
      end else begin
`ifdef CSC_ZPAD_EN
        emit  = 1'b1;
        v_d   = '0;
        z_d   = ZMAX_C;
        run_d = '0;
`else
        // Run stays saturated; the column cannot be represented exactly.
        fmt_err = 1'b1;
`endif
      end
    end else begin
      run_d = run_q;
    end
  end

  // Run counter and entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      v_q   <= '0;
      z_q   <= '0;
    end else begin
      run_q <= run_d;
      v_q   <= v_d;
      z_q   <= z_d;
    end
  end

  assign v = v_q;
  assign z = z_q;

endmodule

// File: rtl/csc_encoder.sv
// Dense column stream to CSC (v/z entries + column pointers) encoder; FSM, counters, RAM strobes.
// Build option CSC_ZPAD_EN: pad entries for long zero runs (see csc_entry_gen).
module csc_encoder
  import csc_pkg::*;
#(
  parameter int D_WIDTH      = D_WIDTH_DEF,
  parameter int A_WIDTH      = A_WIDTH_DEF,
  parameter int W_ADDR_WIDTH = W_ADDR_WIDTH_DEF
) (
  input logic          clk,
  input logic          rst,
  csc_encoder_if.slave bus
);

  localparam logic [W_ADDR_WIDTH-1:0] CAP_C = W_ADDR_WIDTH'(max_code(W_ADDR_WIDTH));
  localparam logic [W_ADDR_WIDTH-1:0] ONE_W = W_ADDR_WIDTH'(1'b1);
  localparam logic [A_WIDTH-1:0]      ONE_A = A_WIDTH'(1'b1);

  state_e                  state_q, state_d;
  logic [A_WIDTH-1:0]      cols_q, cols_d;
  logic [A_WIDTH-1:0]      col_q, col_d;
  logic [W_ADDR_WIDTH-1:0] count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic                    vz_w_en_q, vz_w_en_d;
  logic [W_ADDR_WIDTH-1:0] vz_w_addr_q, vz_w_addr_d;
  logic                    p_w_en_q, p_w_en_d;
  logic [A_WIDTH-1:0]      p_w_addr_q, p_w_addr_d;
  logic [W_ADDR_WIDTH-1:0] p_data_q, p_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_ovf_q, err_ovf_d;

  logic                    beat_s;
  logic                    col_start_s;
  logic                    emit_s;
  logic                    fmt_err_s;
  logic                    write_s;
  logic                    drop_s;
  logic [W_ADDR_WIDTH-1:0] count_next_s;
  logic [D_WIDTH-1:0]      v_s;
  logic [A_WIDTH-1:0]      z_s;

  assign beat_s       = (state_q == STREAM) && in_ready_q && bus.in_valid;
  assign col_start_s  = (state_q != STREAM);
  assign write_s      = emit_s && (count_q < CAP_C);
  assign drop_s       = emit_s && !(count_q < CAP_C);
  assign count_next_s = write_s ? (count_q + ONE_W) : count_q;

  csc_entry_gen #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_entry_gen (
    .clk       (clk),
    .rst       (rst),
    .beat      (beat_s),
    .data      (bus.in_data),
    .col_start (col_start_s),
    .emit      (emit_s),
    .fmt_err   (fmt_err_s),
    .v         (v_s),
    .z         (z_s)
  );

  // Next-state, counters and registered RAM strobes.
  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    col_d       = col_q;
    count_d     = count_next_s;
    vz_w_en_d   = write_s;
    vz_w_addr_d = write_s ? count_q : vz_w_addr_q;
    p_w_en_d    = 1'b0;
    p_w_addr_d  = p_w_addr_q;
    p_data_d    = p_data_q;
    err_ovf_d   = err_ovf_q | drop_s | fmt_err_s;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = INIT_P;
          cols_d     = bus.cfg_cols;
          col_d      = '0;
          count_d    = '0;
          err_ovf_d  = 1'b0;
          p_w_en_d   = 1'b1;
          p_w_addr_d = '0;
          p_data_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      INIT_P: begin
        if (cols_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Pointer carries the count including an entry from this same last beat.
        if (beat_s && bus.in_last) begin
          state_d    = CLOSE_COL;
          p_w_en_d   = 1'b1;
          p_w_addr_d = col_q + ONE_A;
          p_data_d   = count_next_s;
          col_d      = col_q + ONE_A;
        end else begin
          state_d = STREAM;
        end
      end
      CLOSE_COL: begin
        if (col_q == cols_q) begin
          state_d = DONE;
        end else begin
          state_d = STREAM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == STREAM);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cols_q      <= '0;
      col_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      vz_w_en_q   <= 1'b0;
      vz_w_addr_q <= '0;
      p_w_en_q    <= 1'b0;
      p_w_addr_q  <= '0;
      p_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      col_q       <= col_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      vz_w_en_q   <= vz_w_en_d;
      vz_w_addr_q <= vz_w_addr_d;
      p_w_en_q    <= p_w_en_d;
      p_w_addr_q  <= p_w_addr_d;
      p_data_q    <= p_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.vz_w_en   = vz_w_en_q;
  assign bus.vz_w_addr = vz_w_addr_q;
  assign bus.v_data    = v_s;
  assign bus.z_data    = z_s;
  assign bus.p_w_en    = p_w_en_q;
  assign bus.p_w_addr  = p_w_addr_q;
  assign bus.p_data    = p_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_csc_encoder.sv
// Bench for csc_encoder: table of matrices, behavioural model feeding a write scoreboard.
module tb_csc_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csc_encoder_if #(.D_WIDTH(16), .A_WIDTH(4), .W_ADDR_WIDTH(4)) bus ();

  csc_encoder #(.D_WIDTH(16), .A_WIDTH(4), .W_ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] v;
    logic [3:0]  z;
  } vz_t;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] data;
  } p_t;

  typedef struct {
    int                 ncols;
    logic [2:0][7:0]    rows;
    logic [23:0][15:0]  d;
    bit                 gaps;
    int                 exp_vz;
    int                 exp_plast;
    bit                 exp_err;
  } case_t;

  localparam int NCASES = 6;
  case_t cases [NCASES];

  vz_t vz_q[$];
  p_t  p_q[$];
  vz_t mon_vz;
  p_t  mon_p;

  int total = 0;
  int bad = 0;
  int m_count, m_run, m_col;
  bit m_err;
  int vz_seen, busy_cyc;
  logic [3:0] last_p;
  bit prev_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_emit(input logic [15:0] v, input int z);
    vz_t e;
    if (m_count < 15) begin
      e.addr = 4'(m_count);
      e.v    = v;
      e.z    = 4'(z);
      vz_q.push_back(e);
      m_count++;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic m_push_p(input int a, input int d);
    p_t e;
    e.addr = 4'(a);
    e.data = 4'(d);
    p_q.push_back(e);
  endtask

  task automatic m_beat(input logic [15:0] d, input bit last);
    if (d != 16'd0) begin
      m_emit(d, m_run);
      m_run = 0;
    end else if (m_run < 15) begin
      m_run++;
    end else begin
`ifdef CSC_ZPAD_EN
      m_emit(16'd0, 15);
      m_run = 0;
`else
      m_err = 1'b1;
`endif
    end
    if (last) begin
      m_col++;
      m_push_p(m_col, m_count);
      m_run = 0;
    end
  endtask

  task automatic drive_beat(input logic [15:0] d, input bit last);
    int g;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) check("ready_timeout", 32'd1, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    m_beat(d, last);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 16'($urandom);
  endtask

  task automatic start_model(input int ncols);
    m_count = 0; m_run = 0; m_col = 0; m_err = 1'b0;
    vz_seen = 0; busy_cyc = 0;
    bus.cfg_cols = 4'(ncols);
    bus.start    = 1'b1;
    m_push_p(0, 0);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.cfg_cols = 4'($urandom);
  endtask

  task automatic run_case(input int i);
    int k, g, nr, rows_tot;
    start_model(cases[i].ncols);
    k = 0;
    rows_tot = 0;
    for (int c = 0; c < cases[i].ncols; c++) begin
      nr = int'(cases[i].rows[c]);
      rows_tot += nr;
      for (int r = 0; r < nr; r++) begin
        drive_beat(cases[i].d[k], r == nr - 1);
        if (cases[i].gaps && (k % 2 == 0)) begin
          bus.in_data  = 16'($urandom);
          bus.start    = (k == 2);
          bus.cfg_cols = 4'd1;
          @(posedge clk); #1;
          bus.start = 1'b0;
        end
        k++;
      end
    end
    g = 0;
    while (bus.done !== 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check($sformatf("c%0d_done_seen", i), 32'(bus.done), 32'd1);
    check($sformatf("c%0d_err_ovf", i), 32'(bus.err_ovf), 32'(cases[i].exp_err));
    check($sformatf("c%0d_err_model", i), 32'(bus.err_ovf), 32'(m_err));
    @(posedge clk); #1;
    check($sformatf("c%0d_done_pulse", i), 32'(bus.done), 32'd0);
    check($sformatf("c%0d_busy_idle", i), 32'(bus.busy), 32'd0);
    check($sformatf("c%0d_vz_count", i), 32'(vz_seen), 32'(cases[i].exp_vz));
    check($sformatf("c%0d_p_last", i), 32'(last_p), 32'(cases[i].exp_plast));
    check($sformatf("c%0d_queues_empty", i), 32'(vz_q.size() + p_q.size()), 32'd0);
    if (!cases[i].gaps)
      check($sformatf("c%0d_cycles", i), 32'(busy_cyc), 32'(2 + rows_tot + cases[i].ncols));
  endtask

  // Write monitor: every strobe must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.vz_w_en === 1'b1) begin
        vz_seen++;
        if (vz_q.size() == 0) begin
          check("vz_unexpected", 32'd1, 32'd0);
        end else begin
          mon_vz = vz_q.pop_front();
          check("vz_addr", 32'(bus.vz_w_addr), 32'(mon_vz.addr));
          check("vz_v", 32'(bus.v_data), 32'(mon_vz.v));
          check("vz_z", 32'(bus.z_data), 32'(mon_vz.z));
        end
      end
      if (bus.p_w_en === 1'b1) begin
        last_p = bus.p_data;
        if (p_q.size() == 0) begin
          check("p_unexpected", 32'd1, 32'd0);
        end else begin
          mon_p = p_q.pop_front();
          check("p_addr", 32'(bus.p_w_addr), 32'(mon_p.addr));
          check("p_data", 32'(bus.p_data), 32'(mon_p.data));
        end
      end
      if (bus.done === 1'b1) check("done_after_p", 32'(prev_p), 32'd1);
      prev_p = (bus.p_w_en === 1'b1);
      if (bus.busy === 1'b1) busy_cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NCASES; i++) begin
      cases[i].ncols = 0;
      cases[i].rows  = '0;
      cases[i].d     = '0;
      cases[i].gaps  = 1'b0;
      cases[i].exp_vz = 0;
      cases[i].exp_plast = 0;
      cases[i].exp_err = 1'b0;
    end
    // [0,5,0,0,7]
    cases[0].ncols = 1; cases[0].rows[0] = 8'd5;
    cases[0].d[1] = 16'd5; cases[0].d[4] = 16'd7;
    cases[0].exp_vz = 2; cases[0].exp_plast = 2;
    // [0,0] then [3]
    cases[1].ncols = 2; cases[1].rows[0] = 8'd2; cases[1].rows[1] = 8'd1;
    cases[1].d[2] = 16'd3;
    cases[1].exp_vz = 1; cases[1].exp_plast = 1;
    // 16 zeros then 9
    cases[2].ncols = 1; cases[2].rows[0] = 8'd17; cases[2].d[16] = 16'd9;
`ifdef CSC_ZPAD_EN
    cases[2].exp_vz = 2; cases[2].exp_plast = 2; cases[2].exp_err = 1'b0;
`else
    cases[2].exp_vz = 1; cases[2].exp_plast = 1; cases[2].exp_err = 1'b1;
`endif
    // 16 nonzeros 1..16, last one dropped
    cases[3].ncols = 1; cases[3].rows[0] = 8'd16;
    for (int j = 0; j < 16; j++) cases[3].d[j] = 16'(j + 1);
    cases[3].exp_vz = 15; cases[3].exp_plast = 15; cases[3].exp_err = 1'b1;
    // gapped 3-column stream with a start pulse while busy
    cases[4].ncols = 3; cases[4].gaps = 1'b1;
    cases[4].rows[0] = 8'd4; cases[4].rows[1] = 8'd3; cases[4].rows[2] = 8'd2;
    cases[4].d[1] = 16'd8; cases[4].d[3] = 16'd9; cases[4].d[7] = 16'd4;
    cases[4].exp_vz = 3; cases[4].exp_plast = 3;
    // zero columns
    cases[5].ncols = 0;

    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_cols = 4'd0;
    bus.in_valid = 1'b0; bus.in_data = 16'd0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_vz_w_en", 32'(bus.vz_w_en), 32'd0);
    check("rst_p_w_en", 32'(bus.p_w_en), 32'd0);
    check("rst_vz_addr", 32'(bus.vz_w_addr), 32'd0);
    check("rst_v_data", 32'(bus.v_data), 32'd0);
    check("rst_z_data", 32'(bus.z_data), 32'd0);
    check("rst_p_addr", 32'(bus.p_w_addr), 32'd0);
    check("rst_p_data", 32'(bus.p_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err_ovf", 32'(bus.err_ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NCASES; i++) run_case(i);

    // Reset in the middle of a stream
    start_model(2);
    drive_beat(16'h1234, 1'b0);
    drive_beat(16'h0000, 1'b0);
    drive_beat(16'h0042, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0077;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_vz_w_en", 32'(bus.vz_w_en), 32'd0);
    check("midrst_p_w_en", 32'(bus.p_w_en), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("postrst_vz_w_en", 32'(bus.vz_w_en), 32'd0);
    check("postrst_queues", 32'(vz_q.size() + p_q.size()), 32'd0);
    run_case(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
